prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Boot-time program loader that acts as the writer side of the processor's 32-word instruction/data memory port. It accepts a byte stream over a valid/ready handshake, packs bytes into 16-bit words with the high byte first, and writes them to memory addresses 0 upward. It checks a trailing XOR checksum word. On success it releases the hold on the processor; on failure it keeps the processor held.

Parameters:
ADDR_W, 5, memory address width; matches the 5-bit memory address port
DATA_W, 16, memory word width
DEPTH, 32, maximum words per load; must equal 2**ADDR_W

Ports:
clk  input  1  system clock; all state updates on the rising edge
proc_rst  input  1  asynchronous, active-low reset
load_start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE
load_len  input  6  number of payload words, legal range 1..32; latched on an accepted load_start
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both 1
mem_addr  output  ADDR_W  memory write address
mem_data_out  output  DATA_W  memory write data
mem_write  output  1  one-cycle memory write strobe
cpu_hold  output  1  1 holds the processor in reset
load_done  output  1  level; last load verified
load_err  output  1  level; last load request or checksum failed

Behaviour:
- Reset (proc_rst=0, asynchronous): state=IDLE; byte_ready=0, mem_write=0, mem_addr=0, mem_data_out=0, cpu_hold=1, load_done=0, load_err=0; internal addr/len/chk/byte registers cleared.
- All outputs are registered or decoded purely from the state register. No combinational path from byte_valid to byte_ready.
- States: IDLE, HI, LO, WRITE, CHK_HI, CHK_LO, VERIFY, DONE.
- IDLE / DONE, load_start=1 with load_len in 1..32:
  - latch len; addr=0; chk=0; load_done=0; load_err=0; cpu_hold=1; go to HI.
- IDLE / DONE, load_start=1 with load_len=0 or >32:
  - load_err=1; load_done=0; cpu_hold=1; go to IDLE.
- load_start is ignored in every other state.
- HI: byte_ready=1. On transfer, hi=byte_in; go to LO.
- LO: byte_ready=1. On transfer, lo=byte_in; go to WRITE.
- Without a transfer, HI and LO hold indefinitely (no timeout).
- WRITE (exactly one cycle): byte_ready=0; mem_write=1; mem_addr=addr; mem_data_out={hi,lo}; chk ^= {hi,lo}.
  - If addr==len-1, go to CHK_HI.
  - Otherwise addr=addr+1 and go to HI.
  - addr never wraps: len is at most 32, so the maximum addr is 31.
- mem_write is 0 in every state except WRITE. mem_addr and mem_data_out hold their last values outside WRITE.
- CHK_HI, CHK_LO: receive the expected checksum word high byte then low byte, with the same handshake as HI/LO; go to VERIFY.
- VERIFY (one cycle, byte_ready=0):
  - Checksum is chk, i.e. the XOR of all payload words.
  - If chk equals the received word: load_done=1, cpu_hold=0, go to DONE.
  - Otherwise: load_err=1, cpu_hold=1, go to IDLE.
- DONE: cpu_hold=0 and load_done=1 until an accepted load_start. That load_start reasserts cpu_hold on the next edge, before any memory write.
- Throughput: with byte_valid held at 1, each word takes 3 cycles (HI, LO, WRITE). A full load takes 3*len + 3 cycles from entering HI to entering DONE.
- Reset mid-load: immediate return to IDLE state and reset values. Words already written stay in memory. cpu_hold=1, so the processor cannot execute a partial image.
- Bytes offered while byte_ready=0 are not consumed. The source must hold them stable until a transfer occurs.

Test Plan:
1. Reset with byte_valid=1 -> byte_ready=0, cpu_hold=1, mem_write=0, load_done=0, load_err=0.
2. load_len=2; bytes 12,34,AB,CD,B9,F9 with continuous valid -> writes 0x1234 to addr 0, then 0xABCD to addr 1, one mem_write per word; load_done=1 and cpu_hold=0 exactly 9 cycles after entering HI.
3. Same stream with checksum bytes B9,F8 -> load_err=1, cpu_hold stays 1, state returns to IDLE; both words are still written.
4. load_len=0 and, separately, load_len=33 -> load_err=1, no byte_ready, no mem_write.
5. load_len=32 with random byte_valid gaps -> 32 writes to addr 0..31 in order, no wrap; mem_write never asserted during a gap; correct checksum gives load_done=1.
6. proc_rst pulsed low after 5 words of a 10-word load -> outputs at reset values immediately; a following clean 1-word load completes with load_done=1.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a byte stream, packs big-endian 16-bit
// words, writes them to instruction memory from address 0 upward, verifies a
// trailing XOR checksum word and releases the processor hold only on success.
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_write,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HI     = 3'd1,
    LO     = 3'd2,
    WRITE  = 3'd3,
    CHK_HI = 3'd4,
    CHK_LO = 3'd5,
    VERIFY = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t            state_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] chk_r;
  logic [7:0]        hi_r;
  logic [7:0]        lo_r;
  logic              transfer_s;
  logic              last_word_s;

  // Running checksum: fold one payload word into the accumulated XOR.
  function automatic logic [DATA_W-1:0] chk_step(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction

  // A load length is usable only if it is nonzero and fits the memory.
  function automatic logic len_ok(input logic [ADDR_W:0] len);
    return (len != {(ADDR_W+1){1'b0}}) && (len <= (ADDR_W+1)'(DEPTH));
  endfunction

  // Handshake and write strobe are pure decodes of the state register, so
  // byte_valid never reaches byte_ready combinationally.
  assign byte_ready  = (state_r == HI) || (state_r == LO) ||
                       (state_r == CHK_HI) || (state_r == CHK_LO);
  assign mem_write   = (state_r == WRITE);
  assign transfer_s  = byte_valid & byte_ready;
  assign last_word_s = ({1'b0, addr_r} == (len_r - (ADDR_W+1)'(1)));

  // Loader sequencer: state, datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state_r      <= IDLE;
      len_r        <= '0;
      addr_r       <= '0;
      chk_r        <= '0;
      hi_r         <= 8'h00;
      lo_r         <= 8'h00;
      mem_addr     <= '0;
      mem_data_out <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (load_start) begin
            if (len_ok(load_len)) begin
              len_r     <= load_len;
              addr_r    <= '0;
              chk_r     <= '0;
              load_done <= 1'b0;
              load_err  <= 1'b0;
              cpu_hold  <= 1'b1;
              state_r   <= HI;
            end else begin
              load_err  <= 1'b1;
              load_done <= 1'b0;
              cpu_hold  <= 1'b1;
              state_r   <= IDLE;
            end
          end else begin
            state_r <= state_r;
          end
        end
        HI: begin
          if (transfer_s) begin
            hi_r    <= byte_in;
            state_r <= LO;
          end else begin
            state_r <= HI;
          end
        end
        LO: begin
          // Present address and data for the single WRITE cycle that follows.
          if (transfer_s) begin
            lo_r         <= byte_in;
            mem_addr     <= addr_r;
            mem_data_out <= {hi_r, byte_in};
            state_r      <= WRITE;
          end else begin
            state_r <= LO;
          end
        end
        WRITE: begin
          chk_r <= chk_step(chk_r, {hi_r, lo_r});
          if (last_word_s) begin
            state_r <= CHK_HI;
          end else begin
            addr_r  <= addr_r + ADDR_W'(1);
            state_r <= HI;
          end
        end
        CHK_HI: begin
          if (transfer_s) begin
            hi_r    <= byte_in;
            state_r <= CHK_LO;
          end else begin
            state_r <= CHK_HI;
          end
        end
        CHK_LO: begin
          if (transfer_s) begin
            lo_r    <= byte_in;
            state_r <= VERIFY;
          end else begin
            state_r <= CHK_LO;
          end
        end
        VERIFY: begin
          if (chk_r == {hi_r, lo_r}) begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
            state_r   <= DONE;
          end else begin
            load_err  <= 1'b1;
            cpu_hold  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          cpu_hold <= 1'b1;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of whole loads plus hand-written
// sequences for latency, long gapped load and reset in the middle of a load.
module tb_prog_loader;

  logic        clk;
  logic        proc_rst;
  logic        load_start;
  logic [5:0]  load_len;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data_out;
  logic        mem_write;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int          pass_cnt;
  int          total_cnt;
  int          wr_cnt;
  bit          rdy_seen;
  logic [15:0] mem_model [32];

  typedef struct {
    logic [5:0]        len;
    logic [0:3][15:0]  w;
    logic [15:0]       chk;
    bit                done;
  } vec_t;

  vec_t vecs [7];

  prog_loader dut (
    .clk          (clk),
    .proc_rst     (proc_rst),
    .load_start   (load_start),
    .load_len     (load_len),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_write    (mem_write),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endfunction

  // Write monitor: capture every memory write and check address order.
  always @(negedge clk) begin
    if (byte_ready) rdy_seen = 1'b1;
    if (mem_write) begin
      check("wr_addr_order", {27'd0, mem_addr}, wr_cnt);
      check("wr_no_ready", {31'd0, byte_ready}, 32'd0);
      mem_model[mem_addr] = mem_data_out;
      wr_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!byte_ready && n < 100);
    if (!byte_ready) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic start_load(input logic [5:0] len);
    @(posedge clk);
    #1;
    load_start = 1'b1;
    load_len   = len;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(load_done || load_err) && n < 400);
    if (!(load_done || load_err)) check("result_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int errs;
    int exp_wr;
    logic [15:0] w;
    logic [15:0] chk;

    pass_cnt   = 0;
    total_cnt  = 0;
    wr_cnt     = 0;
    rdy_seen   = 1'b0;
    proc_rst   = 1'b0;
    load_start = 1'b0;
    load_len   = 6'd0;
    byte_in    = 8'hAA;
    byte_valid = 1'b1;

    vecs[0] = '{len: 6'd2,  w: {16'h1234, 16'hABCD, 16'h0000, 16'h0000}, chk: 16'hB9F9, done: 1'b1};
    vecs[1] = '{len: 6'd2,  w: {16'h1234, 16'hABCD, 16'h0000, 16'h0000}, chk: 16'hB9F8, done: 1'b0};
    vecs[2] = '{len: 6'd1,  w: {16'h00FF, 16'h0000, 16'h0000, 16'h0000}, chk: 16'h00FF, done: 1'b1};
    vecs[3] = '{len: 6'd3,  w: {16'h0001, 16'h0002, 16'h0004, 16'h0000}, chk: 16'h0007, done: 1'b1};
    vecs[4] = '{len: 6'd4,  w: {16'hFFFF, 16'hFFFF, 16'h1111, 16'h2222}, chk: 16'h3333, done: 1'b1};
    vecs[5] = '{len: 6'd0,  w: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, chk: 16'h0000, done: 1'b0};
    vecs[6] = '{len: 6'd33, w: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, chk: 16'h0000, done: 1'b0};

    // Reset held with byte_valid asserted.
    #12;
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
    check("rst_mem_write",  {31'd0, mem_write},  32'd0);
    check("rst_load_done",  {31'd0, load_done},  32'd0);
    check("rst_load_err",   {31'd0, load_err},   32'd0);
    check("rst_mem_addr",   {27'd0, mem_addr},   32'd0);
    @(posedge clk);
    #1;
    proc_rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_no_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;

    // Latency: 2-word load with continuous valid, DONE 9 cycles after HI.
    wr_cnt = 0;
    start_load(6'd2);
    fork
      begin
        send_word(16'h1234, 0);
        send_word(16'hABCD, 0);
        send_word(16'hB9F9, 0);
      end
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!load_done && n < 100);
      end
    join
    check("lat_cycles",   n, 32'd9);
    check("lat_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("lat_writes",   wr_cnt, 32'd2);
    check("lat_word0",    {16'd0, mem_model[0]}, 32'h1234);
    check("lat_word1",    {16'd0, mem_model[1]}, 32'hABCD);

    // Table of complete loads.
    for (int i = 0; i < 7; i++) begin
      wr_cnt   = 0;
      rdy_seen = 1'b0;
      for (int k = 0; k < 32; k++) mem_model[k] = 16'hDEAD;
      start_load(vecs[i].len);
      if (vecs[i].len >= 6'd1 && vecs[i].len <= 6'd32) begin
        exp_wr = int'(vecs[i].len);
        for (int j = 0; j < int'(vecs[i].len); j++) send_word(vecs[i].w[j], 0);
        send_word(vecs[i].chk, 0);
        wait_result(n);
      end else begin
        exp_wr = 0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        check("badlen_no_ready", {31'd0, rdy_seen}, 32'd0);
      end
      errs = 0;
      for (int j = 0; j < exp_wr; j++) if (mem_model[j] !== vecs[i].w[j]) errs++;
      check($sformatf("v%0d_done", i),  {31'd0, load_done},  {31'd0, vecs[i].done});
      check($sformatf("v%0d_err", i),   {31'd0, load_err},   {31'd0, !vecs[i].done});
      check($sformatf("v%0d_hold", i),  {31'd0, cpu_hold},   {31'd0, !vecs[i].done});
      check($sformatf("v%0d_writes", i), wr_cnt, exp_wr);
      check($sformatf("v%0d_data", i),  errs, 32'd0);
      check($sformatf("v%0d_ready", i), {31'd0, byte_ready}, 32'd0);
    end

    // Full 32-word load with random valid gaps.
    wr_cnt = 0;
    chk    = 16'h0000;
    start_load(6'd32);
    for (int i = 0; i < 32; i++) begin
      w   = 16'(i * 16'h0123) ^ 16'h5AA5;
      chk = chk ^ w;
      send_word(w, int'($urandom_range(0, 2)));
    end
    send_word(chk, 1);
    wait_result(n);
    errs = 0;
    for (int i = 0; i < 32; i++) if (mem_model[i] !== (16'(i * 16'h0123) ^ 16'h5AA5)) errs++;
    check("full_writes", wr_cnt, 32'd32);
    check("full_data",   errs, 32'd0);
    check("full_done",   {31'd0, load_done}, 32'd1);
    check("full_hold",   {31'd0, cpu_hold},  32'd0);

    // Reset after 5 words of a 10-word load.
    wr_cnt = 0;
    start_load(6'd10);
    for (int i = 0; i < 5; i++) send_word(16'h1000 + 16'(i), 0);
    @(negedge clk);
    #2;
    proc_rst = 1'b0;
    #1;
    check("mid_writes",     wr_cnt, 32'd5);
    check("mid_mem_write",  {31'd0, mem_write},  32'd0);
    check("mid_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_cpu_hold",   {31'd0, cpu_hold},   32'd1);
    check("mid_load_done",  {31'd0, load_done},  32'd0);
    check("mid_load_err",   {31'd0, load_err},   32'd0);
    check("mid_mem_addr",   {27'd0, mem_addr},   32'd0);
    @(posedge clk);
    #1;
    proc_rst = 1'b1;
    wr_cnt = 0;
    start_load(6'd1);
    send_word(16'hC0DE, 0);
    send_word(16'hC0DE, 0);
    wait_result(n);
    check("post_rst_done",  {31'd0, load_done}, 32'd1);
    check("post_rst_hold",  {31'd0, cpu_hold},  32'd0);
    check("post_rst_word",  {16'd0, mem_model[0]}, 32'hC0DE);

    // An accepted start from DONE reasserts the hold on the next edge.
    start_load(6'd1);
    check("restart_hold", {31'd0, cpu_hold},  32'd1);
    check("restart_done", {31'd0, load_done}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
